// File: rtl/param_cache_controller.sv
// param_cache_controller
//   N-way set-associative, write-back / write-allocate data cache controller
//   with true-LRU replacement, byte write strobes, whole-cache flush and
//   saturating hit/miss counters.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   cpu_read / cpu_write       single-word request strobes, sampled in IDLE
//   cpu_addr                   byte address (offset bits below the word ignored)
//   cpu_write_data, cpu_wstrb  write word and byte enables
//   cpu_read_data              read word, held until the next read completes
//   cpu_ready                  one-cycle completion pulse
//   flush_req / flush_done     flush start (sampled in IDLE) / completion pulse
//   busy                       high whenever the controller is not IDLE
//   mem_read / mem_write       block fill / writeback requests, held to mem_ready
//   mem_addr                   block-aligned memory address
//   mem_write_data             victim line being written back
//   mem_read_data, mem_ready   fill data and one-cycle completion pulse
//   hit_count, miss_count      saturating statistics counters
module param_cache_controller #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAYS        = 4,
    parameter int unsigned SETS        = 128,
    parameter int unsigned BLOCK_BYTES = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_read,
    input  logic                     cpu_write,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [DATA_W-1:0]        cpu_write_data,
    input  logic [DATA_W/8-1:0]      cpu_wstrb,
    output logic [DATA_W-1:0]        cpu_read_data,
    output logic                     cpu_ready,
    input  logic                     flush_req,
    output logic                     flush_done,
    output logic                     busy,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [BLOCK_BYTES*8-1:0] mem_write_data,
    input  logic [BLOCK_BYTES*8-1:0] mem_read_data,
    input  logic                     mem_ready,
    output logic [CNT_W-1:0]         hit_count,
    output logic [CNT_W-1:0]         miss_count
);

    localparam int unsigned BLOCK_W = BLOCK_BYTES * 8;
    localparam int unsigned STRB_W  = DATA_W / 8;
    localparam int unsigned WORDS   = BLOCK_BYTES / STRB_W;
    localparam int unsigned OFF_W   = $clog2(BLOCK_BYTES);
    localparam int unsigned BSEL_W  = $clog2(STRB_W);
    localparam int unsigned WOFF_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned IDX_W   = $clog2(SETS);
    localparam int unsigned TAG_W   = ADDR_W - OFF_W - IDX_W;
    localparam int unsigned WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [3:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        REFILL,
        UPDATE,
        RESPOND,
        FLUSH_SCAN,
        FLUSH_WB,
        FLUSH_DONE
    } state_t;

    typedef logic [WAYS-1:0][WAY_W-1:0] ages_t;

    state_t state, state_nx;

    // Line storage
    logic [WAYS-1:0]    valid_arr [SETS];
    logic [WAYS-1:0]    dirty_arr [SETS];
    ages_t              age_arr   [SETS];
    logic [TAG_W-1:0]   tag_arr   [SETS][WAYS];
    logic [BLOCK_W-1:0] data_arr  [SETS][WAYS];

    // Latched request and miss bookkeeping
    logic [ADDR_W-1:0]  req_addr;
    logic [DATA_W-1:0]  req_wdata;
    logic [STRB_W-1:0]  req_wstrb;
    logic               req_write;
    logic [WAY_W-1:0]   victim_way;
    logic [ADDR_W-1:0]  wb_addr;
    logic [BLOCK_W-1:0] wb_line;
    logic [BLOCK_W-1:0] fill_line;

    // Flush walk pointer
    logic [IDX_W-1:0]   fl_set;
    logic [WAY_W-1:0]   fl_way;

    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [WOFF_W-1:0]  req_word;
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic [WAY_W-1:0]   vic_way;
    logic               vic_dirty;
    logic               fl_dirty;
    logic               fl_last;

    assign req_idx = req_addr[OFF_W +: IDX_W];
    assign req_tag = req_addr[ADDR_W-1 -: TAG_W];

    if (WORDS > 1) begin : g_word_sel
        assign req_word = req_addr[OFF_W-1:BSEL_W];
    end else begin : g_single_word
        assign req_word = '0;
    end

    function automatic logic [DATA_W-1:0] get_word(input logic [BLOCK_W-1:0] line,
                                                   input logic [WOFF_W-1:0]  word);
        int unsigned base;
        base = 32'(word) * DATA_W;
        return line[base +: DATA_W];
    endfunction

    function automatic logic [BLOCK_W-1:0] merge_word(input logic [BLOCK_W-1:0] line,
                                                      input logic [WOFF_W-1:0]  word,
                                                      input logic [DATA_W-1:0]  data,
                                                      input logic [STRB_W-1:0]  strb);
        logic [BLOCK_W-1:0] res;
        int unsigned        base;
        res  = line;
        base = 32'(word) * DATA_W;
        for (int unsigned b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                res[base + b*8 +: 8] = data[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // Touched way becomes youngest; only ways younger than it age by one,
    // so the set's ages stay a permutation of 0..WAYS-1.
    function automatic ages_t lru_touch(input ages_t ages, input logic [WAY_W-1:0] acc);
        ages_t res;
        res = ages;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == acc) begin
                res[w] = '0;
            end else if (ages[w] < ages[acc]) begin
                res[w] = ages[w] + 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_arr[req_idx][w] && (tag_arr[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Oldest way first, then overridden by the lowest-index invalid way.
    always_comb begin
        logic [WAY_W-1:0] max_age;
        vic_way = '0;
        max_age = age_arr[req_idx][0];
        for (int unsigned w = 1; w < WAYS; w++) begin
            if (age_arr[req_idx][w] > max_age) begin
                max_age = age_arr[req_idx][w];
                vic_way = WAY_W'(w);
            end
        end
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!valid_arr[req_idx][WAYS-1-i]) begin
                vic_way = WAY_W'(WAYS-1-i);
            end
        end
    end

    assign vic_dirty = valid_arr[req_idx][vic_way] && dirty_arr[req_idx][vic_way];
    assign fl_dirty  = valid_arr[fl_set][fl_way] && dirty_arr[fl_set][fl_way];
    assign fl_last   = (fl_way == WAY_W'(WAYS-1)) && (fl_set == IDX_W'(SETS-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        cpu_ready      = 1'b0;
        flush_done     = 1'b0;
        busy           = (state != IDLE);
        case (state)
            IDLE: begin
                if (cpu_write || cpu_read) begin
                    state_nx = LOOKUP;
                end else if (flush_req) begin
                    state_nx = FLUSH_SCAN;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    state_nx = RESPOND;
                end else if (vic_dirty) begin
                    state_nx = WRITEBACK;
                end else begin
                    state_nx = REFILL;
                end
            end
            WRITEBACK: begin
                mem_write      = 1'b1;
                mem_addr       = wb_addr;
                mem_write_data = wb_line;
                if (mem_ready) begin
                    state_nx = REFILL;
                end
            end
            REFILL: begin
                mem_read = 1'b1;
                mem_addr = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                if (mem_ready) begin
                    state_nx = UPDATE;
                end
            end
            UPDATE: begin
                state_nx = RESPOND;
            end
            RESPOND: begin
                cpu_ready = 1'b1;
                state_nx  = IDLE;
            end
            FLUSH_SCAN: begin
                if (fl_dirty) begin
                    state_nx = FLUSH_WB;
                end else if (fl_last) begin
                    state_nx = FLUSH_DONE;
                end
            end
            FLUSH_WB: begin
                mem_write      = 1'b1;
                mem_addr       = wb_addr;
                mem_write_data = wb_line;
                // Dirty is cleared on completion, so the scan re-visits this
                // entry once, finds it clean and advances.
                if (mem_ready) begin
                    state_nx = FLUSH_SCAN;
                end
            end
            FLUSH_DONE: begin
                flush_done = 1'b1;
                state_nx   = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Control/status state (reset)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    age_arr[s][w] <= WAY_W'(w);
                end
            end
            req_addr      <= '0;
            req_wdata     <= '0;
            req_wstrb     <= '0;
            req_write     <= 1'b0;
            victim_way    <= '0;
            wb_addr       <= '0;
            fl_set        <= '0;
            fl_way        <= '0;
            cpu_read_data <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_write) begin
                        req_addr  <= cpu_addr;
                        req_wdata <= cpu_write_data;
                        req_wstrb <= cpu_wstrb;
                        req_write <= 1'b1;
                    end else if (cpu_read) begin
                        req_addr  <= cpu_addr;
                        req_write <= 1'b0;
                    end else if (flush_req) begin
                        fl_set <= '0;
                        fl_way <= '0;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        if (hit_count != '1) begin
                            hit_count <= hit_count + 1'b1;
                        end
                        if (req_write) begin
                            dirty_arr[req_idx][hit_way] <= 1'b1;
                        end else begin
                            cpu_read_data <= get_word(data_arr[req_idx][hit_way], req_word);
                        end
                        age_arr[req_idx] <= lru_touch(age_arr[req_idx], hit_way);
                    end else begin
                        if (miss_count != '1) begin
                            miss_count <= miss_count + 1'b1;
                        end
                        victim_way <= vic_way;
                        wb_addr    <= {tag_arr[req_idx][vic_way], req_idx, {OFF_W{1'b0}}};
                    end
                end
                UPDATE: begin
                    valid_arr[req_idx][victim_way] <= 1'b1;
                    dirty_arr[req_idx][victim_way] <= req_write;
                    age_arr[req_idx] <= lru_touch(age_arr[req_idx], victim_way);
                    if (!req_write) begin
                        cpu_read_data <= get_word(fill_line, req_word);
                    end
                end
                FLUSH_SCAN: begin
                    if (fl_dirty) begin
                        wb_addr <= {tag_arr[fl_set][fl_way], fl_set, {OFF_W{1'b0}}};
                    end else if (fl_way == WAY_W'(WAYS-1)) begin
                        fl_way <= '0;
                        fl_set <= fl_set + 1'b1;
                    end else begin
                        fl_way <= fl_way + 1'b1;
                    end
                end
                FLUSH_WB: begin
                    if (mem_ready) begin
                        dirty_arr[fl_set][fl_way] <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Line payload storage (no reset needed: guarded by valid bits)
    always_ff @(posedge clk) begin
        case (state)
            LOOKUP: begin
                if (hit && req_write) begin
                    data_arr[req_idx][hit_way] <= merge_word(data_arr[req_idx][hit_way],
                                                             req_word, req_wdata, req_wstrb);
                end
                if (!hit) begin
                    wb_line <= data_arr[req_idx][vic_way];
                end
            end
            REFILL: begin
                if (mem_ready) begin
                    fill_line <= mem_read_data;
                end
            end
            UPDATE: begin
                tag_arr[req_idx][victim_way] <= req_tag;
                if (req_write) begin
                    data_arr[req_idx][victim_way] <= merge_word(fill_line, req_word,
                                                                req_wdata, req_wstrb);
                end else begin
                    data_arr[req_idx][victim_way] <= fill_line;
                end
            end
            FLUSH_SCAN: begin
                if (fl_dirty) begin
                    wb_line <= data_arr[fl_set][fl_way];
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_param_cache_controller.sv
// tb_param_cache_controller
//   Directed bench for param_cache_controller (default geometry, 4-bit
//   counters so saturation is reachable). Memory returns a fill pattern in
//   which every word equals its own byte address.
module tb_param_cache_controller;

    localparam int MEM_LAT = 2;

    logic         clk;
    logic         rst_n;
    logic         cpu_read;
    logic         cpu_write;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_write_data;
    logic [3:0]   cpu_wstrb;
    logic [31:0]  cpu_read_data;
    logic         cpu_ready;
    logic         flush_req;
    logic         flush_done;
    logic         busy;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [511:0] mem_write_data;
    logic [511:0] mem_read_data;
    logic         mem_ready;
    logic [3:0]   hit_count;
    logic [3:0]   miss_count;

    param_cache_controller #(
        .ADDR_W(32), .DATA_W(32), .WAYS(4), .SETS(128), .BLOCK_BYTES(64), .CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_write_data(cpu_write_data), .cpu_wstrb(cpu_wstrb),
        .cpu_read_data(cpu_read_data), .cpu_ready(cpu_ready),
        .flush_req(flush_req), .flush_done(flush_done), .busy(busy),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .mem_ready(mem_ready), .hit_count(hit_count), .miss_count(miss_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] d0;
    } tx_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        bit          exp_hit;
        int          exp_nrd;
        logic [31:0] exp_rd_addr;
        int          exp_nwr;
        logic [31:0] exp_wr_addr;
        logic [31:0] exp_wr_d0;
    } vec_t;

    tx_t  txq[$];
    vec_t vecs[17];
    int   checks = 0;
    int   errors = 0;
    int   overlap_err = 0;
    int   drop_err = 0;
    int   n_ready = 0;
    int   n_fd = 0;

    function automatic logic [511:0] fill_pat(input logic [31:0] a);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = a + 32'(i*4);
        return l;
    endfunction

    function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [3:0] strb, input logic [31:0] erd, input bit hit,
                                input int nrd, input logic [31:0] rda, input int nwr,
                                input logic [31:0] wra, input logic [31:0] wrd);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wd; v.strb = strb; v.exp_rd = erd;
        v.exp_hit = hit; v.exp_nrd = nrd; v.exp_rd_addr = rda; v.exp_nwr = nwr;
        v.exp_wr_addr = wra; v.exp_wr_d0 = wrd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory responder: acknowledges after MEM_LAT idle negedges, logs traffic.
    initial begin
        int lat;
        bit last_wr;
        mem_ready = 1'b0;
        mem_read_data = '0;
        lat = 0;
        last_wr = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_read && mem_write) overlap_err++;
            if (mem_ready) begin
                mem_ready = 1'b0;
                if (last_wr ? mem_write : mem_read) drop_err++;
            end else if (mem_read || mem_write) begin
                if (lat >= MEM_LAT) begin
                    lat = 0;
                    mem_ready = 1'b1;
                    last_wr = mem_write;
                    if (mem_write) begin
                        txq.push_back('{1'b1, mem_addr, mem_write_data[31:0]});
                    end else begin
                        mem_read_data = fill_pat(mem_addr);
                        txq.push_back('{1'b0, mem_addr, 32'h0});
                    end
                end else begin
                    lat++;
                end
            end else begin
                lat = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cpu_ready) n_ready++;
            if (flush_done) n_fd++;
        end
    end

    task automatic check_traffic(input string name, input int nrd, input logic [31:0] rda,
                                 input int nwr, input logic [31:0] wra, input logic [31:0] wrd);
        int ar = 0;
        int aw = 0;
        logic [31:0] fra = 32'hx;
        logic [31:0] fwa = 32'hx;
        logic [31:0] fwd = 32'hx;
        foreach (txq[i]) begin
            if (txq[i].wr) begin
                if (aw == 0) begin fwa = txq[i].addr; fwd = txq[i].d0; end
                aw++;
            end else begin
                if (ar == 0) fra = txq[i].addr;
                ar++;
            end
        end
        chk({name, "_nrd"}, ar, nrd);
        chk({name, "_nwr"}, aw, nwr);
        if (nrd > 0) chk({name, "_rd_addr"}, fra, rda);
        if (nwr > 0) begin
            chk({name, "_wr_addr"}, fwa, wra);
            chk({name, "_wr_d0"}, fwd, wrd);
        end
        if (nrd > 0 && nwr > 0) chk({name, "_wr_before_rd"}, txq[0].wr, 1);
    endtask

    task automatic cpu_op(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] strb, output logic [31:0] rd, output int cyc,
                          output bit ok);
        @(negedge clk);
        cpu_write = wr; cpu_read = !wr; cpu_addr = addr;
        cpu_write_data = wd; cpu_wstrb = strb;
        @(posedge clk); #1;
        cpu_write = 1'b0; cpu_read = 1'b0;
        cyc = 1;
        while (!cpu_ready && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        ok = cpu_ready;
        rd = cpu_read_data;
        @(posedge clk); #1;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        logic [31:0] rd;
        int          cyc;
        bit          ok;
        for (int i = lo; i <= hi; i++) begin
            txq.delete();
            cpu_op(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, cyc, ok);
            chk($sformatf("vec%0d_ready", i), ok, 1);
            if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            if (vecs[i].exp_hit) chk($sformatf("vec%0d_hit_latency", i), cyc, 2);
            check_traffic($sformatf("vec%0d", i), vecs[i].exp_nrd, vecs[i].exp_rd_addr,
                          vecs[i].exp_nwr, vecs[i].exp_wr_addr, vecs[i].exp_wr_d0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_read"}, mem_read, 0);
        chk({tag, "_mem_write"}, mem_write, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata_zero"}, (mem_write_data == '0), 1);
        chk({tag, "_cpu_ready"}, cpu_ready, 0);
        chk({tag, "_cpu_rdata"}, cpu_read_data, 0);
        chk({tag, "_flush_done"}, flush_done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_hit_count"}, hit_count, 0);
        chk({tag, "_miss_count"}, miss_count, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rd;
        int          cyc;
        bit          ok;
        int          r0;
        int          f0;

        // wr addr wdata strb | exp_rd hit | nrd rd_addr | nwr wr_addr wr_d0
        vecs[0]  = mk(1, 32'h0,     32'hDEADBEEF, 4'hF, 32'h0,        0, 1, 32'h0,     0, 0, 0);
        vecs[1]  = mk(0, 32'h0,     32'h0,        4'h0, 32'hDEADBEEF, 1, 0, 32'h0,     0, 0, 0);
        vecs[2]  = mk(1, 32'h0,     32'hAABBCCDD, 4'h5, 32'h0,        1, 0, 32'h0,     0, 0, 0);
        vecs[3]  = mk(0, 32'h0,     32'h0,        4'h0, 32'hDEBBBEDD, 1, 0, 32'h0,     0, 0, 0);
        vecs[4]  = mk(1, 32'h0,     32'h1000,     4'hF, 32'h0,        0, 1, 32'h0,     0, 0, 0);
        vecs[5]  = mk(1, 32'h2000,  32'h1001,     4'hF, 32'h0,        0, 1, 32'h2000,  0, 0, 0);
        vecs[6]  = mk(1, 32'h4000,  32'h1002,     4'hF, 32'h0,        0, 1, 32'h4000,  0, 0, 0);
        vecs[7]  = mk(1, 32'h6000,  32'h1003,     4'hF, 32'h0,        0, 1, 32'h6000,  0, 0, 0);
        vecs[8]  = mk(0, 32'h0,     32'h0,        4'h0, 32'h1000,     1, 0, 32'h0,     0, 0, 0);
        vecs[9]  = mk(1, 32'h8000,  32'h1004,     4'hF, 32'h0,        0, 1, 32'h8000,  1, 32'h2000, 32'h1001);
        vecs[10] = mk(0, 32'h0,     32'h0,        4'h0, 32'h1000,     1, 0, 32'h0,     0, 0, 0);
        // After flush: all lines clean, evictions must not write back
        vecs[11] = mk(0, 32'h4000,  32'h0,        4'h0, 32'h1002,     1, 0, 32'h0,     0, 0, 0);
        vecs[12] = mk(0, 32'hA000,  32'h0,        4'h0, 32'hA000,     0, 1, 32'hA000,  0, 0, 0);
        vecs[13] = mk(0, 32'hC000,  32'h0,        4'h0, 32'hC000,     0, 1, 32'hC000,  0, 0, 0);
        vecs[14] = mk(0, 32'hE000,  32'h0,        4'h0, 32'hE000,     0, 1, 32'hE000,  0, 0, 0);
        vecs[15] = mk(0, 32'h10000, 32'h0,        4'h0, 32'h10000,    0, 1, 32'h10000, 0, 0, 0);
        vecs[16] = mk(0, 32'h4000,  32'h0,        4'h0, 32'h4000,     0, 1, 32'h4000,  0, 0, 0);

        rst_n = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0;
        cpu_write_data = '0; cpu_wstrb = '0; flush_req = 1'b0;
        #12;
        check_all_zero("reset");
        do_reset();

        // Write miss / read hit / byte strobes
        run_vecs(0, 1);
        chk("counts_after_wr_rd_hit", hit_count, 1);
        chk("counts_after_wr_rd_miss", miss_count, 1);
        run_vecs(2, 3);

        // LRU eviction
        do_reset();
        run_vecs(4, 10);
        chk("lru_hit_count", hit_count, 2);
        chk("lru_miss_count", miss_count, 5);

        // Flush with ways 0..3 of set 0 dirty (tags 0,4,2,3); scan is way order
        txq.delete();
        f0 = n_fd;
        @(negedge clk); flush_req = 1'b1;
        @(posedge clk); #1; flush_req = 1'b0;
        cyc = 0;
        while (!flush_done && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("flush_done_seen", flush_done, 1);
        chk("flush_hit_unchanged", hit_count, 2);
        chk("flush_miss_unchanged", miss_count, 5);
        repeat (4) @(posedge clk);
        #1;
        chk("flush_done_pulses", n_fd - f0, 1);
        chk("flush_busy_after", busy, 0);
        chk("flush_nwr", txq.size(), 4);
        if (txq.size() == 4) begin
            chk("flush_wr0_addr", txq[0].addr, 32'h0);
            chk("flush_wr0_d0", txq[0].d0, 32'h1000);
            chk("flush_wr1_addr", txq[1].addr, 32'h8000);
            chk("flush_wr1_d0", txq[1].d0, 32'h1004);
            chk("flush_wr2_addr", txq[2].addr, 32'h4000);
            chk("flush_wr2_d0", txq[2].d0, 32'h1002);
            chk("flush_wr3_addr", txq[3].addr, 32'h6000);
            chk("flush_wr3_d0", txq[3].d0, 32'h1003);
            chk("flush_all_writes", txq[0].wr & txq[1].wr & txq[2].wr & txq[3].wr, 1);
        end
        run_vecs(11, 16);

        // Simultaneous read+write+flush: only the write runs; read during REFILL dropped
        txq.delete();
        r0 = n_ready;
        f0 = n_fd;
        @(negedge clk);
        cpu_read = 1'b1; cpu_write = 1'b1; flush_req = 1'b1;
        cpu_addr = 32'h40; cpu_write_data = 32'h55AA55AA; cpu_wstrb = 4'hF;
        @(posedge clk); #1;
        cpu_read = 1'b0; cpu_write = 1'b0; flush_req = 1'b0;
        cyc = 0;
        while (!mem_read && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("busy_in_refill", busy, 1);
        chk("refill_seen", mem_read, 1);
        @(negedge clk); cpu_read = 1'b1; cpu_addr = 32'h80;
        @(negedge clk); cpu_read = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("simul_ready_pulses", n_ready - r0, 1);
        chk("simul_no_flush", n_fd - f0, 0);
        check_traffic("simul", 1, 32'h40, 0, 0, 0);
        txq.delete();
        cpu_op(0, 32'h40, 0, 0, rd, cyc, ok);
        chk("simul_readback", rd, 32'h55AA55AA);
        chk("simul_readback_latency", cyc, 2);
        check_traffic("simul_readback", 0, 0, 0, 0, 0);

        // Reset while a refill is outstanding
        @(negedge clk); cpu_read = 1'b1; cpu_addr = 32'h1000_0000;
        @(posedge clk); #1; cpu_read = 1'b0;
        cyc = 0;
        while (!mem_read && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rst_refill_seen", mem_read, 1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        txq.delete();
        cpu_op(0, 32'h40, 0, 0, rd, cyc, ok);
        chk("postrst_ready", ok, 1);
        chk("postrst_rdata", rd, 32'h40);
        check_traffic("postrst", 1, 32'h40, 0, 0, 0);
        chk("postrst_hit_count", hit_count, 0);
        chk("postrst_miss_count", miss_count, 1);

        // Hit counter saturation
        for (int i = 0; i < 20; i++) cpu_op(0, 32'h40, 0, 0, rd, cyc, ok);
        chk("sat_rdata", rd, 32'h40);
        chk("sat_hit_count", hit_count, 4'hF);
        chk("sat_miss_count", miss_count, 1);

        chk("mem_rd_wr_overlap", overlap_err, 0);
        chk("mem_req_drop", drop_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_cache_controller.md
Name: param_cache_controller

Overview:
Parametrised N-way set-associative write-back, write-allocate data cache controller. It sits between a single-word CPU port and a block-wide main-memory port. It generalises way count, set count and block size, and adds the following:
- true-LRU replacement
- byte write strobes
- a whole-cache flush operation
- hit/miss statistics counters

Parameters:
ADDR_W, 32, CPU/memory address width
DATA_W, 32, CPU word width (multiple of 8)
WAYS, 4, associativity (power of 2, 1..8)
SETS, 128, sets per way (power of 2)
BLOCK_BYTES, 64, line size in bytes (power of 2, at least DATA_W/8); BLOCK_W = BLOCK_BYTES*8
CNT_W, 32, width of statistics counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cpu_read  in  1  read request, sampled in IDLE only
cpu_write  in  1  write request, sampled in IDLE only
cpu_addr  in  ADDR_W  byte address; word-aligned, low offset bits ignored
cpu_write_data  in  DATA_W  write word
cpu_wstrb  in  DATA_W/8  byte enables for writes
cpu_read_data  out  DATA_W  read word, valid while cpu_ready=1, held until next read completes
cpu_ready  out  1  one-cycle completion pulse
flush_req  in  1  start flush, sampled in IDLE only
flush_done  out  1  one-cycle pulse when flush completes
busy  out  1  high in every state except IDLE
mem_read  out  1  block fill request, held until mem_ready
mem_write  out  1  block writeback request, held until mem_ready
mem_addr  out  ADDR_W  block-aligned address {tag,index,0}
mem_write_data  out  BLOCK_W  victim line
mem_read_data  in  BLOCK_W  fill data, valid with mem_ready
mem_ready  in  1  one-cycle memory completion pulse
hit_count  out  CNT_W  saturating count of hits
miss_count  out  CNT_W  saturating count of misses

Behaviour:
- Address split: offset = log2(BLOCK_BYTES) bits, index = log2(SETS) bits, tag = the remainder.
- Reset (async, rst_n=0):
  - state goes to IDLE.
  - All valid, dirty and LRU bits are cleared, and LRU ages are initialised to way index.
  - All outputs are 0, including both counters.
  - An in-flight memory transaction is abandoned; any mem_ready arriving after reset deasserts is ignored in IDLE.
- States: IDLE, LOOKUP, WRITEBACK, REFILL, UPDATE, RESPOND, FLUSH_SCAN, FLUSH_WB, FLUSH_DONE.
- IDLE:
  - If cpu_write=1: latch addr, data and wstrb, go to LOOKUP. cpu_write wins when both cpu_write and cpu_read are high; the read is dropped.
  - Else if cpu_read=1: latch addr, go to LOOKUP.
  - Else if flush_req=1: go to FLUSH_SCAN with set=0, way=0. A CPU request in the same cycle takes priority over flush.
  - Requests arriving while busy=1 are ignored and not queued.
- LOOKUP: compare the tag against all valid ways of the set.
  - Hit: increment hit_count; a read selects the word, a write merges the strobed bytes and sets dirty; update LRU; go to RESPOND.
  - Miss: increment miss_count and choose a victim. The victim is the lowest-index invalid way if any exists, else the way with the maximum LRU age.
  - Dirty victim: go to WRITEBACK. Otherwise go to REFILL.
- WRITEBACK: mem_write=1, mem_addr={victim tag,index,0}, mem_write_data=victim line. On mem_ready, go to REFILL.
- REFILL: mem_read=1, mem_addr={req tag,index,0}. On mem_ready, capture mem_read_data and go to UPDATE.
- UPDATE: install the line as valid; on a write, merge the strobed bytes and set dirty, else dirty=0. Update LRU, go to RESPOND.
- RESPOND: cpu_ready=1 for exactly one cycle, cpu_read_data driven for reads, go to IDLE.
- Latency:
  - Hit: request sampled at edge N, cpu_ready high in cycle N+2.
  - Clean miss: 3 cycles plus memory latency.
  - Dirty miss: additionally one writeback handshake.
- LRU update:
  - The accessed way's age becomes 0.
  - Ways whose age is lower than the accessed way's old age increment by 1.
  - Ages remain a permutation of 0..WAYS-1.
- mem_read and mem_write are never high together. Each drops in the cycle after mem_ready.
- Flush:
  - FLUSH_SCAN visits each (set, way) in order: way fastest, then set.
  - A valid dirty line goes to FLUSH_WB, which performs the writeback handshake, clears dirty, and returns to the scan.
  - Lines stay valid, and LRU is unchanged.
  - After the last set and last way, FLUSH_DONE pulses flush_done for one cycle, then returns to IDLE.
  - Clean lines cost 1 cycle each.
- Counters saturate at all-ones. Flush does not count hits or misses.

Test Plan:
- Write miss then read hit: default params, write 0xDEADBEEF, wstrb 4'hF, to 0x00000000. Required: mem_read at 0x00000000, no mem_write, then cpu_ready. A following read of 0x00000000 returns 0xDEADBEEF with no memory traffic, cpu_ready 2 cycles after the request; hit_count=1, miss_count=1.
- Byte strobes: write 0xAABBCCDD, wstrb 4'b0101, to 0x00000000, then read it back. Required: 0xDEBBBEDD.
- LRU eviction:
  - Write 0x1000+t to tag t, set 0, address t<<13, for t=0..3.
  - Read 0x00000000.
  - Write 0x1004 to 0x00008000.
  - Required: mem_write at 0x00002000 with mem_write_data[31:0]=0x1001, then mem_read at 0x00008000.
  - A read of 0x00000000 then hits and returns 0x1000.
- Flush: with 4 dirty lines in set 0, pulse flush_req. Required: exactly 4 mem_write transactions (addresses 0x0, 0x4000, 0x6000, 0x8000), then one flush_done pulse. A re-read of 0x00004000 hits with no memory traffic, and a later eviction of that line produces no writeback.
- Simultaneous and busy requests: cpu_read and cpu_write high together with flush_req → only the write executes. A cpu_read pulsed during REFILL is ignored, with no extra cpu_ready.
- Reset mid-refill: drop rst_n while mem_read=1. Required: all outputs 0 immediately. After release, a read of a previously written address misses (mem_read issued) and counters restart from 0.
